life_support_ctrl: RTL and testbench
====================================

// Module: life_support_ctrl
// PURPOSE
//  Command-side controller for the life-support datapath. It reads back shield, temp, power,
//  O2 and fatal status, and drives the mode/chrg/o2sup commands that the datapath consumes.
//  It is a priority FSM with hysteresis, minimum-dwell and attack-hold counters.
//  It sits between the bridge/threat inputs and the life-support block.
// PARAMETERS
//  n         8    status data width (unsigned)
//  PWR_LO    20   enter RECHARGE when pwr_in < PWR_LO
//  PWR_HI    200  leave RECHARGE when pwr_in >= PWR_HI
//  O2_LO     30   assert o2sup when o2_in < O2_LO
//  O2_HI     220  deassert o2sup when o2_in >= O2_HI
//  SHIELD_LO 50   shield_in < SHIELD_LO is a DEFEND request
//  MIN_DWELL 8    minimum cycles in DEFEND/STEALTH before a lower-priority exit
//  ATK_HOLD  16   cycles DEFEND is held after the last atk_alert
//  FATAL_CLR 4    consecutive fatal_in==0 cycles needed to leave EMERGENCY
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  asynchronous, active-low reset
//  atk_alert   in   1  threat detected (level)
//  stealth_req in   1  bridge requests stealth (level)
//  alarm_clr   in   1  alarm acknowledge; only used with FATAL_LATCH_EN
//  shield_in   in   n  shield status
//  temp_in     in   n  temperature status; readback only, it has no effect on the FSM
//  pwr_in      in   n  power status
//  o2_in       in   n  O2 status
//  fatal_in    in   1  fatal flag from life support
//  mode        out  4  0000 cruise, 0100 defend, 1000 stealth; no other code is ever driven
//  chrg        out  1  charge command
//  o2sup       out  1  O2 supply command
//  alarm       out  1  high while in EMERGENCY
//  state       out  3  current FSM state, for debug/telemetry
// BEHAVIOUR
//  - All outputs are registered. Inputs are sampled on a clk edge; outputs reflect them after that edge (latency 1).
//  - rst low: state=CRUISE, mode=0000, chrg=0, o2sup=0, alarm=0, all counters 0.
//    Reset takes effect at once and mid-operation; the FSM leaves reset in CRUISE.
//  - States: CRUISE=0, DEFEND=1, STEALTH=2, RECHARGE=3, EMERGENCY=4.
//  - Next-state priority, evaluated every cycle:
//    1. fatal_in=1 -> EMERGENCY, from any state.
//    2. pwr_in < PWR_LO -> RECHARGE, from any state except EMERGENCY. Preempts dwell.
//    3. atk_alert | shield_in < SHIELD_LO -> DEFEND. Allowed from CRUISE at once;
//       from STEALTH only once the dwell counter is done (done = at least MIN_DWELL cycles in the state).
//    4. stealth_req -> STEALTH, from CRUISE only.
//    5. Otherwise stay in the current state, or return to CRUISE when its exit rule holds.
//  - DEFEND: mode=0100.
//    - Hold counter reloads to ATK_HOLD on every atk_alert cycle and decrements by 1 otherwise; it saturates at 0.
//    - Exit to CRUISE when hold=0, dwell is done, and shield_in >= SHIELD_LO.
//  - STEALTH: mode=1000. Exit to CRUISE when stealth_req=0 and dwell is done.
//  - RECHARGE: mode=0000, chrg=1. Exit to CRUISE when pwr_in >= PWR_HI.
//    Values between PWR_LO and PWR_HI hold the current state (hysteresis).
//  - EMERGENCY: mode=0000, chrg=1, o2sup=1, alarm=1. Exit to CRUISE after FATAL_CLR
//    consecutive fatal_in=0 cycles; any fatal_in=1 resets that count to 0.
//  - Dwell counter clears on every state change, counts up, and saturates at MIN_DWELL.
//  - o2sup, outside EMERGENCY: set on o2_in < O2_LO, clear on o2_in >= O2_HI, otherwise hold.
//    On EMERGENCY exit it holds the value it had during EMERGENCY (1) until o2_in >= O2_HI.
//  - All compares are unsigned n-bit. Counters are $clog2(max+1) wide and never wrap.
//  - Simultaneous atk_alert and stealth_req in CRUISE -> DEFEND.
// CONFIGURATION
//  FATAL_LATCH_EN defined:
//    - EMERGENCY is sticky. Exit needs alarm_clr=1 while fatal_in=0; FATAL_CLR is ignored.
//    - alarm_clr is ignored while fatal_in=1.
//  FATAL_LATCH_EN undefined: alarm_clr is ignored and EMERGENCY auto-clears via FATAL_CLR.
// STRUCTURE
//  - Package ls_pkg: state encoding constants and mode codes MODE_CRUISE/MODE_DEFEND/MODE_STEALTH.
//    The life-support block shares these mode codes.
//  - Sub-module ls_hyst #(n,LO,HI)(clk,rst,val,q) is the registered set/clear hysteresis flag.
//    Instantiate it twice: power-low and o2-low.
//  - FSM, dwell/hold/fatal counters and output registers stay in this module.
// TESTING
//  1. Hold rst=0; check all outputs 0 and state=0. Release rst with all inputs idle -> stays CRUISE.
//  2. Pulse atk_alert for 1 cycle -> mode=0100 next cycle. It stays in DEFEND 16 cycles after the alert,
//     then mode=0000. Re-pulse at cycle 10 -> hold extends to 16 cycles after cycle 10.
//  3. stealth_req=1 for 3 cycles -> mode=1000 is held for 8 cycles (dwell), then mode=0000.
//     Then assert stealth_req and atk_alert together -> DEFEND.
//  4. pwr_in=19 while in STEALTH at dwell 2 -> RECHARGE next cycle, chrg=1.
//     pwr_in=199 -> still RECHARGE; pwr_in=200 -> CRUISE, chrg=0.
//  5. o2_in sweep 40 -> 29 -> 100 -> 220: o2sup goes 0, 1, 1, 0.
//  6. fatal_in=1 in DEFEND -> EMERGENCY, alarm=1, o2sup=1, chrg=1.
//     Then fatal_in pattern 0,0,1,0,0,0,0 -> exits only after the last four zeros.
//     Under FATAL_LATCH_EN it stays in EMERGENCY until alarm_clr=1.

Source files
------------

// File: rtl/ls_pkg.sv
// Shared state encoding and mode codes for the life-support controller and datapath.
package ls_pkg;

  typedef enum logic [2:0] {
    ST_CRUISE    = 3'd0,
    ST_DEFEND    = 3'd1,
    ST_STEALTH   = 3'd2,
    ST_RECHARGE  = 3'd3,
    ST_EMERGENCY = 3'd4
  } state_t;

  localparam logic [3:0] MODE_CRUISE  = 4'b0000;
  localparam logic [3:0] MODE_DEFEND  = 4'b0100;
  localparam logic [3:0] MODE_STEALTH = 4'b1000;

  function automatic logic [3:0] mode_of(state_t s);
    case (s)
      ST_DEFEND:  return MODE_DEFEND;
      ST_STEALTH: return MODE_STEALTH;
      default:    return MODE_CRUISE;
    endcase
  endfunction

endpackage

// File: rtl/life_support_ctrl_if.sv
// Status readback and command bundle between the bridge/threat side and the controller.
interface life_support_ctrl_if #(
  parameter int n = 8
);
  logic         atk_alert;
  logic         stealth_req;
  logic         alarm_clr;
  logic [n-1:0] shield_in;
  logic [n-1:0] temp_in;
  logic [n-1:0] pwr_in;
  logic [n-1:0] o2_in;
  logic         fatal_in;
  logic [3:0]   mode;
  logic         chrg;
  logic         o2sup;
  logic         alarm;
  logic [2:0]   state;

  modport master (
    output atk_alert, stealth_req, alarm_clr, shield_in, temp_in, pwr_in, o2_in, fatal_in,
    input  mode, chrg, o2sup, alarm, state
  );

  modport slave (
    input  atk_alert, stealth_req, alarm_clr, shield_in, temp_in, pwr_in, o2_in, fatal_in,
    output mode, chrg, o2sup, alarm, state
  );
endinterface

// File: rtl/ls_hyst.sv
// Registered set/clear hysteresis flag: sets below LO, clears at or above HI, holds between.
module ls_hyst #(
  parameter int n  = 8,
  parameter int LO = 20,
  parameter int HI = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] val,
  output logic         q
);
  localparam logic [n-1:0] LO_V = n'(LO);
  localparam logic [n-1:0] HI_V = n'(HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (val < LO_V) begin
      q <= 1'b1;
    end else if (val >= HI_V) begin
      q <= 1'b0;
    end
  end
endmodule

// File: rtl/life_support_ctrl.sv
// Priority FSM driving mode/chrg/o2sup/alarm with dwell, attack-hold and fatal-clear counters.
// Build option: FATAL_LATCH_EN makes EMERGENCY sticky until alarm_clr.
module life_support_ctrl
  import ls_pkg::*;
#(
  parameter int n         = 8,
  parameter int PWR_LO    = 20,
  parameter int PWR_HI    = 200,
  parameter int O2_LO     = 30,
  parameter int O2_HI     = 220,
  parameter int SHIELD_LO = 50,
  parameter int MIN_DWELL = 8,
  parameter int ATK_HOLD  = 16,
  parameter int FATAL_CLR = 4
) (
  input logic                clk,
  input logic                rst,
  life_support_ctrl_if.slave bus
);
  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam int HW = $clog2(ATK_HOLD + 1);
  localparam int FW = $clog2(FATAL_CLR + 1);

  localparam logic [n-1:0] PWR_LO_V    = n'(PWR_LO);
  localparam logic [n-1:0] PWR_HI_V    = n'(PWR_HI);
  localparam logic [n-1:0] SHIELD_LO_V = n'(SHIELD_LO);

  state_t        state_reg, state_next;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic [HW-1:0] hold_reg,  hold_next;
  logic [FW-1:0] fcnt_reg,  fcnt_next;
  logic [3:0]    mode_reg,  mode_next;
  logic          alarm_reg, alarm_next;

  logic          pwr_lo, pwr_hi, shield_lo, threat, dwell_done;
  logic [n-1:0]  pwr_val, o2_val;
  logic          chrg_q, o2sup_q;

  assign pwr_lo    = bus.pwr_in < PWR_LO_V;
  assign pwr_hi    = bus.pwr_in >= PWR_HI_V;
  assign shield_lo = bus.shield_in < SHIELD_LO_V;
  assign threat    = bus.atk_alert | shield_lo;
  // dwell_reg holds one less than the cycles already spent in the state
  assign dwell_done = dwell_reg >= DW'(MIN_DWELL - 1);

  always_comb begin
    hold_next = '0;
    fcnt_next = '0;
    if (bus.atk_alert) begin
      hold_next = HW'(ATK_HOLD);
    end else if (hold_reg != '0) begin
      hold_next = hold_reg - HW'(1);
    end
    if (state_reg == ST_EMERGENCY && !bus.fatal_in) begin
      fcnt_next = (fcnt_reg == FW'(FATAL_CLR)) ? fcnt_reg : fcnt_reg + FW'(1);
    end
  end

  // next-state: fatal, then low power, then per-state rules
  always_comb begin
    state_next = state_reg;
    if (bus.fatal_in) begin
      state_next = ST_EMERGENCY;
    end else if (state_reg != ST_EMERGENCY && pwr_lo) begin
      state_next = ST_RECHARGE;
    end else begin
      case (state_reg)
        ST_CRUISE: begin
          if (threat)               state_next = ST_DEFEND;
          else if (bus.stealth_req) state_next = ST_STEALTH;
        end
        ST_DEFEND: begin
          if (hold_next == '0 && dwell_done && !threat) state_next = ST_CRUISE;
        end
        ST_STEALTH: begin
          if (threat && dwell_done)                 state_next = ST_DEFEND;
          else if (!bus.stealth_req && dwell_done)  state_next = ST_CRUISE;
        end
        ST_RECHARGE: begin
          if (pwr_hi) state_next = ST_CRUISE;
        end
        ST_EMERGENCY: begin
`ifdef FATAL_LATCH_EN
          if (bus.alarm_clr) state_next = ST_CRUISE;
`else
          if (fcnt_next >= FW'(FATAL_CLR)) state_next = ST_CRUISE;
`endif
        end
        default: state_next = ST_CRUISE;
      endcase
    end
  end

  always_comb begin
    mode_next  = mode_of(state_next);
    alarm_next = (state_next == ST_EMERGENCY);
    if (state_next != state_reg) begin
      dwell_next = '0;
    end else if (dwell_reg == DW'(MIN_DWELL)) begin
      dwell_next = dwell_reg;
    end else begin
      dwell_next = dwell_reg + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_CRUISE;
      dwell_reg <= '0;
      hold_reg  <= '0;
      fcnt_reg  <= '0;
      mode_reg  <= MODE_CRUISE;
      alarm_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      dwell_reg <= dwell_next;
      hold_reg  <= hold_next;
      fcnt_reg  <= fcnt_next;
      mode_reg  <= mode_next;
      alarm_reg <= alarm_next;
    end
  end

  // Charge flag is set on entry to RECHARGE/EMERGENCY and cleared on any other next state.
  always_comb begin
    pwr_val = '1;
    if (state_next == ST_EMERGENCY)     pwr_val = '0;
    else if (state_next == ST_RECHARGE) pwr_val = bus.pwr_in;
  end

  // Forcing "O2 low" during EMERGENCY leaves the flag set afterwards until O2 recovers.
  assign o2_val = (state_next == ST_EMERGENCY) ? '0 : bus.o2_in;

  ls_hyst #(.n(n), .LO(PWR_LO), .HI(PWR_HI)) u_pwr_low (
    .clk (clk),
    .rst (rst),
    .val (pwr_val),
    .q   (chrg_q)
  );

  ls_hyst #(.n(n), .LO(O2_LO), .HI(O2_HI)) u_o2_low (
    .clk (clk),
    .rst (rst),
    .val (o2_val),
    .q   (o2sup_q)
  );

  assign bus.mode  = mode_reg;
  assign bus.chrg  = chrg_q;
  assign bus.o2sup = o2sup_q;
  assign bus.alarm = alarm_reg;
  assign bus.state = state_reg;
endmodule

// File: tb/tb_life_support_ctrl.sv
// Directed bench for life_support_ctrl: reset, defend hold, stealth dwell, recharge, O2, emergency.
module tb_life_support_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   passed;

  life_support_ctrl_if #(.n(8)) bus ();

  life_support_ctrl #(.n(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.mode  !== 4'b0000) $display("FAIL reset_mode: got %b expected 0000", bus.mode);   else passed++;
    checks++; if (bus.chrg  !== 1'b0)    $display("FAIL reset_chrg: got %b expected 0", bus.chrg);      else passed++;
    checks++; if (bus.o2sup !== 1'b0)    $display("FAIL reset_o2sup: got %b expected 0", bus.o2sup);    else passed++;
    checks++; if (bus.alarm !== 1'b0)    $display("FAIL reset_alarm: got %b expected 0", bus.alarm);    else passed++;
    checks++; if (bus.state !== 3'd0)    $display("FAIL reset_state: got %0d expected 0", bus.state);   else passed++;
    rst = 1'b1;
    repeat (3) step();
    checks++; if (bus.state !== 3'd0) $display("FAIL idle_state: got %0d expected 0", bus.state); else passed++;
    // mid-operation asynchronous reset
    bus.atk_alert = 1'b1;
    step();
    bus.atk_alert = 1'b0;
    checks++; if (bus.state !== 3'd1) $display("FAIL pre_reset_defend: got %0d expected 1", bus.state); else passed++;
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.state !== 3'd0)    $display("FAIL async_reset_state: got %0d expected 0", bus.state); else passed++;
    checks++; if (bus.mode  !== 4'b0000) $display("FAIL async_reset_mode: got %b expected 0000", bus.mode);  else passed++;
    #1 rst = 1'b1;
    step();
    checks++; if (bus.state !== 3'd0) $display("FAIL post_reset_state: got %0d expected 0", bus.state); else passed++;
    $display("reset: done, state=%0d", bus.state);
  endtask

  task automatic test_attack();
    bus.atk_alert = 1'b1;
    step();
    bus.atk_alert = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.mode !== 4'b0100) $display("FAIL atk_hold[%0d]: got %b expected 0100", i, bus.mode); else passed++;
      step();
    end
    checks++; if (bus.mode  !== 4'b0000) $display("FAIL atk_exit_mode: got %b expected 0000", bus.mode);   else passed++;
    checks++; if (bus.state !== 3'd0)    $display("FAIL atk_exit_state: got %0d expected 0", bus.state);  else passed++;
    $display("attack: single pulse, mode=%b", bus.mode);
    // re-pulse ten cycles after the first alert
    bus.atk_alert = 1'b1;
    step();
    bus.atk_alert = 1'b0;
    repeat (9) step();
    bus.atk_alert = 1'b1;
    step();
    bus.atk_alert = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.mode !== 4'b0100) $display("FAIL atk_rehold[%0d]: got %b expected 0100", i, bus.mode); else passed++;
      step();
    end
    checks++; if (bus.mode !== 4'b0000) $display("FAIL atk_reexit_mode: got %b expected 0000", bus.mode); else passed++;
    $display("attack: re-pulse, mode=%b", bus.mode);
  endtask

  task automatic test_stealth();
    bus.stealth_req = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.mode !== 4'b1000) $display("FAIL stealth_dwell[%0d]: got %b expected 1000", i, bus.mode); else passed++;
      if (i == 1) bus.stealth_req = 1'b0;
      step();
    end
    checks++; if (bus.mode  !== 4'b0000) $display("FAIL stealth_exit_mode: got %b expected 0000", bus.mode);  else passed++;
    checks++; if (bus.state !== 3'd0)    $display("FAIL stealth_exit_state: got %0d expected 0", bus.state); else passed++;
    $display("stealth: dwell exit, mode=%b", bus.mode);
    bus.stealth_req = 1'b1;
    bus.atk_alert   = 1'b1;
    step();
    bus.stealth_req = 1'b0;
    bus.atk_alert   = 1'b0;
    checks++; if (bus.mode  !== 4'b0100) $display("FAIL both_req_mode: got %b expected 0100", bus.mode);  else passed++;
    checks++; if (bus.state !== 3'd1)    $display("FAIL both_req_state: got %0d expected 1", bus.state); else passed++;
    repeat (16) step();
    checks++; if (bus.state !== 3'd0) $display("FAIL both_req_exit: got %0d expected 0", bus.state); else passed++;
    $display("stealth: simultaneous request, state=%0d", bus.state);
  endtask

  task automatic test_recharge();
    bus.stealth_req = 1'b1;
    repeat (3) step();
    checks++; if (bus.state !== 3'd2) $display("FAIL rchg_pre_stealth: got %0d expected 2", bus.state); else passed++;
    bus.pwr_in      = 8'd19;
    bus.stealth_req = 1'b0;
    step();
    checks++; if (bus.state !== 3'd3)    $display("FAIL rchg_enter_state: got %0d expected 3", bus.state); else passed++;
    checks++; if (bus.chrg  !== 1'b1)    $display("FAIL rchg_enter_chrg: got %b expected 1", bus.chrg);    else passed++;
    checks++; if (bus.mode  !== 4'b0000) $display("FAIL rchg_enter_mode: got %b expected 0000", bus.mode); else passed++;
    bus.pwr_in = 8'd199;
    step();
    checks++; if (bus.state !== 3'd3) $display("FAIL rchg_199_state: got %0d expected 3", bus.state); else passed++;
    checks++; if (bus.chrg  !== 1'b1) $display("FAIL rchg_199_chrg: got %b expected 1", bus.chrg);    else passed++;
    bus.pwr_in = 8'd200;
    step();
    checks++; if (bus.state !== 3'd0) $display("FAIL rchg_200_state: got %0d expected 0", bus.state); else passed++;
    checks++; if (bus.chrg  !== 1'b0) $display("FAIL rchg_200_chrg: got %b expected 0", bus.chrg);    else passed++;
    bus.pwr_in = 8'd100;
    $display("recharge: exit at 200, chrg=%b", bus.chrg);
  endtask

  task automatic test_o2();
    logic [7:0] vals [4] = '{8'd40, 8'd29, 8'd100, 8'd220};
    logic       exp  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus.o2_in = vals[i];
      step();
      checks++; if (bus.o2sup !== exp[i]) $display("FAIL o2_sweep[%0d]: got %b expected %b", i, bus.o2sup, exp[i]); else passed++;
      $display("o2: o2_in=%0d o2sup=%b", vals[i], bus.o2sup);
    end
  endtask

  task automatic test_emergency();
    logic       fpat [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef FATAL_LATCH_EN
    logic [2:0] est  [7] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
`else
    logic [2:0] est  [7] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0};
`endif
    bus.o2_in     = 8'd100;
    bus.atk_alert = 1'b1;
    step();
    bus.atk_alert = 1'b0;
    checks++; if (bus.state !== 3'd1) $display("FAIL emg_pre_defend: got %0d expected 1", bus.state); else passed++;
    bus.fatal_in = 1'b1;
    step();
    checks++; if (bus.state !== 3'd4)    $display("FAIL emg_state: got %0d expected 4", bus.state); else passed++;
    checks++; if (bus.alarm !== 1'b1)    $display("FAIL emg_alarm: got %b expected 1", bus.alarm);  else passed++;
    checks++; if (bus.o2sup !== 1'b1)    $display("FAIL emg_o2sup: got %b expected 1", bus.o2sup);  else passed++;
    checks++; if (bus.chrg  !== 1'b1)    $display("FAIL emg_chrg: got %b expected 1", bus.chrg);    else passed++;
    checks++; if (bus.mode  !== 4'b0000) $display("FAIL emg_mode: got %b expected 0000", bus.mode); else passed++;
    for (int i = 0; i < 7; i++) begin
      bus.fatal_in = fpat[i];
      step();
      checks++; if (bus.state !== est[i]) $display("FAIL emg_clear[%0d]: got %0d expected %0d", i, bus.state, est[i]); else passed++;
      $display("emergency: fatal_in=%b state=%0d", fpat[i], bus.state);
    end
`ifdef FATAL_LATCH_EN
    bus.alarm_clr = 1'b1;
    step();
    bus.alarm_clr = 1'b0;
    checks++; if (bus.state !== 3'd0) $display("FAIL emg_latch_clr: got %0d expected 0", bus.state); else passed++;
`endif
    checks++; if (bus.alarm !== 1'b0) $display("FAIL emg_exit_alarm: got %b expected 0", bus.alarm); else passed++;
    checks++; if (bus.chrg  !== 1'b0) $display("FAIL emg_exit_chrg: got %b expected 0", bus.chrg);   else passed++;
    checks++; if (bus.o2sup !== 1'b1) $display("FAIL emg_exit_o2sup: got %b expected 1", bus.o2sup); else passed++;
    bus.o2_in = 8'd220;
    step();
    checks++; if (bus.o2sup !== 1'b0) $display("FAIL emg_o2_release: got %b expected 0", bus.o2sup); else passed++;
    $display("emergency: exit, o2sup=%b", bus.o2sup);
  endtask

  initial begin
    checks          = 0;
    passed          = 0;
    rst             = 1'b0;
    bus.atk_alert   = 1'b0;
    bus.stealth_req = 1'b0;
    bus.alarm_clr   = 1'b0;
    bus.shield_in   = 8'd100;
    bus.temp_in     = 8'd0;
    bus.pwr_in      = 8'd100;
    bus.o2_in       = 8'd100;
    bus.fatal_in    = 1'b0;
    test_reset();
    test_attack();
    test_stealth();
    test_recharge();
    test_o2();
    test_emergency();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
